pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined integer adder/subtractor replacing the single-cycle combinational adder wherever a wide add must be split across clock cycles, e.g. the EX-stage ALU add path or the branch-target adder. The operation is split into `STAGES` equal slices, with carry registered between slices. It supports a valid/stall/flush handshake matching the processor pipeline controls and produces carry, signed-overflow and zero flags.

## Interface
- `word`, default 32: operand/result width in bits; must be a multiple of `STAGES`.
- `STAGES`, default 4: number of pipeline slices (1..word); slice width `CW = word/STAGES`.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands on `a`, `b`, `sub` are valid this cycle.
- `a`  in  word  operand A.
- `b`  in  word  operand B.
- `sub`  in  1  0 = A+B, 1 = A−B (A + ~B + 1).
- `stall`  in  1  hold every pipeline register this cycle.
- `flush`  in  1  invalidate all in-flight operations.
- `result`  out  word  sum/difference.
- `carry`  out  1  raw carry out of the MSB (for subtraction: 1 = no borrow).
- `overflow`  out  1  two's-complement signed overflow.
- `zero`  out  1  `result == 0`.
- `out_valid`  out  1  `result` and flags belong to a valid operation.

## Operation
- Stage k (0..STAGES−1) adds operand slice k (bits `[k*CW +: CW]`) plus the carry registered by stage k−1.
  - Stage 0 carry-in = `sub`.
  - B slice is inverted when `sub` = 1.
- Each stage registers:
  - its sum slice and carry-out;
  - the already-computed lower sum slices;
  - the not-yet-used upper operand slices;
  - the `sub` bit, the MSBs of A and the effective B, and a valid bit.
- Final stage output:
  - `result` = concatenated sum slices.
  - `carry` = carry out of slice STAGES−1.
  - `overflow` = (A[msb] == Beff[msb]) && (result[msb] != A[msb]), where Beff = `b` ^ {word{`sub`}}.
  - `zero` = ~|result.
- Arithmetic is modulo 2^word; no saturation.
- `STAGES`=1 degenerates to a single registered adder.
- Priority, highest first:
  1. `reset`: all registers, including data, cleared to 0.
  2. `flush`: all valid bits cleared at the next edge, data registers unchanged; `flush` overrides `stall`, and `in_valid` on the same cycle is discarded.
  3. `stall`: every register holds, including `out_valid` and the outputs; `in_valid` in a stalled cycle is ignored (the upstream must hold the operation).
  4. Normal advance.
- Bubbles (`in_valid`=0) propagate as invalid slots. Data in invalid slots is don't-care, but flags must still be computed from it (no X).

## Timing
- Reset values: `result`=0, `carry`=0, `overflow`=0, `zero`=0, `out_valid`=0.
  - `zero` and every flag are registered at the output, so all read 0 in reset.
- Latency: an operation sampled at edge N (`stall`=0) is presented with `out_valid`=1 after edge N+STAGES−1 and is visible during the following cycle. Latency is exactly STAGES cycles plus the number of stalled cycles in between.
- Throughput: one operation per unstalled cycle; ordering is strictly preserved.
- Outputs are driven only from registers; no combinational path from inputs to outputs.
- `reset` asserted mid-operation: all in-flight operations are lost and outputs go to reset values immediately, asynchronously. The first edge after deassertion may accept a new operation.
- No critical path longer than one CW-bit adder plus flag logic.

## Test plan
- **Reset**: assert `reset` with `in_valid`=1 and random operands.
  - Required: all outputs 0 during reset.
  - Required: first valid output appears exactly STAGES cycles after the first accepted input.
- **Full carry chain** (word=32, STAGES=4): a=0xFFFFFFFF, b=0x00000001, sub=0.
  - Required after 4 cycles: result=0x00000000, carry=1, overflow=0, zero=1.
- **Signed overflow**:
  - a=0x7FFFFFFF + b=1 → result 0x80000000, overflow=1, carry=0.
  - a=0x80000000 − b=1 (sub=1) → result 0x7FFFFFFF, overflow=1, carry=1.
- **Subtract with borrow**: 5 − 7 → result 0xFFFFFFFE, carry=0, overflow=0, zero=0.
  - Same test with 7 − 7 → result 0, carry=1, zero=1.
- **Stall**: stream 8 back-to-back operations (i + 0x10*i, i=1..8) and stall 3 cycles after the 3rd.
  - Required: 8 results in order, no duplicates or drops.
  - Required: outputs and `out_valid` frozen during the stall; total latency of the stalled operations is 4+3 cycles.
- **Flush and reset mid-stream**: assert `flush` with 3 operations in flight, together with `stall`=1 and `in_valid`=1.
  - Required: `out_valid` stays 0 for the next 4 cycles.
  - Then issue a new operation and assert async `reset` mid-flight.
  - Required: outputs clear without waiting for an edge.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Operand/result bundle for pipe_adder: valid/stall/flush controls in,
// registered sum and flags out.
interface pipe_adder_if #(
    parameter int word = 32
);
    logic            in_valid;
    logic [word-1:0] a;
    logic [word-1:0] b;
    logic            sub;
    logic            stall;
    logic            flush;
    logic [word-1:0] result;
    logic            carry;
    logic            overflow;
    logic            zero;
    logic            out_valid;

    modport master (
        output in_valid, a, b, sub, stall, flush,
        input  result, carry, overflow, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, sub, stall, flush,
        output result, carry, overflow, zero, out_valid
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: the word is split into STAGES slices of CW bits,
// with the carry registered between slices and registered result flags.
module pipe_adder #(
    parameter int word   = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         reset,
    pipe_adder_if.slave  bus
);
    localparam int              CW      = word / STAGES;
    localparam logic [word-1:0] SLICE_M = word'({CW{1'b1}});

    logic [word-1:0] r_sum  [STAGES];
    logic [word-1:0] r_a    [STAGES];
    logic [word-1:0] r_b    [STAGES];
    logic            r_cy   [STAGES];
    logic            r_amsb [STAGES];
    logic            r_bmsb [STAGES];
    logic            r_vld  [STAGES];
    logic            r_ovf;
    logic            r_zero;

    logic [word-1:0] w_ain  [STAGES];
    logic [word-1:0] w_bin  [STAGES];
    logic [word-1:0] w_sin  [STAGES];
    logic [word-1:0] w_sum  [STAGES];
    logic            w_cin  [STAGES];
    logic            w_amsb [STAGES];
    logic            w_bmsb [STAGES];
    logic            w_vin  [STAGES];
    logic [CW:0]     w_add  [STAGES];

    logic [word-1:0] w_beff;
    logic [word-1:0] w_res;
    logic            w_ovf;
    logic            w_zero;

    // B is inverted once at entry; the +1 of subtraction rides in as the stage-0 carry.
    assign w_beff = bus.b ^ {word{bus.sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_ain[k]  = bus.a;
            assign w_bin[k]  = w_beff;
            assign w_sin[k]  = '0;
            assign w_cin[k]  = bus.sub;
            assign w_amsb[k] = bus.a[word-1];
            assign w_bmsb[k] = w_beff[word-1];
            assign w_vin[k]  = bus.in_valid;
        end else begin : g_next
            assign w_ain[k]  = r_a[k-1];
            assign w_bin[k]  = r_b[k-1];
            assign w_sin[k]  = r_sum[k-1];
            assign w_cin[k]  = r_cy[k-1];
            assign w_amsb[k] = r_amsb[k-1];
            assign w_bmsb[k] = r_bmsb[k-1];
            assign w_vin[k]  = r_vld[k-1];
        end

        assign w_add[k] = {1'b0, w_ain[k][k*CW +: CW]}
                        + {1'b0, w_bin[k][k*CW +: CW]}
                        + {{CW{1'b0}}, w_cin[k]};

        // Splice this stage's slice into the partial sum handed down from below.
        assign w_sum[k] = (w_sin[k] & ~(SLICE_M << (k*CW)))
                        | (word'(w_add[k][CW-1:0]) << (k*CW));
    end

    assign w_res  = w_sum[STAGES-1];
    assign w_ovf  = (w_amsb[STAGES-1] == w_bmsb[STAGES-1]) &&
                    (w_res[word-1] != w_amsb[STAGES-1]);
    assign w_zero = ~|w_res;

    // Flush only kills valid bits; data registers keep their contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k]  <= '0;
                r_a[k]    <= '0;
                r_b[k]    <= '0;
                r_cy[k]   <= 1'b0;
                r_amsb[k] <= 1'b0;
                r_bmsb[k] <= 1'b0;
                r_vld[k]  <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (bus.flush) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
            end
        end else if (!bus.stall) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k]  <= w_sum[k];
                r_a[k]    <= w_ain[k];
                r_b[k]    <= w_bin[k];
                r_cy[k]   <= w_add[k][CW];
                r_amsb[k] <= w_amsb[k];
                r_bmsb[k] <= w_bmsb[k];
                r_vld[k]  <= w_vin[k];
            end
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign bus.result    = r_sum[STAGES-1];
    assign bus.carry     = r_cy[STAGES-1];
    assign bus.overflow  = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.out_valid = r_vld[STAGES-1];
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (word=32, STAGES=4): table vectors, scoreboard stream,
// stall / flush / async-reset sequences.
module tb_pipe_adder;
    localparam int W  = 32;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_adder_if #(.word(W)) bus();
    pipe_adder #(.word(W), .STAGES(ST)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef logic [34:0] exp_t;  // {result, carry, overflow, zero}
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_lat = -1;
    exp_t next_exp;
    exp_t q_exp[$];
    int   q_cyc[$];
    int   lat_q[$];
    vec_t tv[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_total++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, req);
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] be;
        logic [32:0] t;
        logic [31:0] r;
        logic        v;
        be = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {32'd0, s};
        r  = t[31:0];
        v  = (a[31] == be[31]) && (r[31] != a[31]);
        return {r, t[32], v, (r == 32'd0)};
    endfunction

    function automatic logic [35:0] outs();
        return {bus.result, bus.carry, bus.overflow, bus.zero, bus.out_valid};
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        next_exp     = model(a, b, s);
    endtask

    // One clock: enqueue accepted op, advance, compare any freshly produced output.
    task automatic cycle();
        logic adv;
        logic fl;
        exp_t got;
        exp_t e;
        int   pc;
        adv = !bus.stall && !bus.flush && !reset;
        fl  = bus.flush;
        if (adv && bus.in_valid) begin
            q_exp.push_back(next_exp);
            q_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fl) begin
            q_exp.delete();
            q_cyc.delete();
        end
        if (adv && bus.out_valid) begin
            got = {bus.result, bus.carry, bus.overflow, bus.zero};
            if (q_exp.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got %h required no output", got);
            end else begin
                e  = q_exp.pop_front();
                pc = q_cyc.pop_front();
                last_lat = cyc - pc;
                lat_q.push_back(last_lat);
                n_out++;
                check("scoreboard", 64'(got), 64'(e));
            end
        end
    endtask

    task automatic drain(input string name);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (ST + 2) cycle();
        check(name, 64'(q_exp.size()), 64'd0);
    endtask

    initial begin
        logic [35:0] snap;
        logic        seen;

        tv[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tv[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tv[5]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        tv[9]  = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tv[10] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};
        tv[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

        // Reset held with live operands on the bus.
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, $urandom, $urandom, 1'b0);
        repeat (3) begin
            cycle();
            drive(1'b1, $urandom, $urandom, $urandom_range(0, 1) == 1);
            check("reset_outputs", 64'(outs()), 64'd0);
        end
        reset = 1'b0;
        n_out = 0;
        drive(1'b1, 32'hCAFE0001, 32'h00001234, 1'b0);
        cycle();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 10 && n_out == 0; i++) cycle();
        check("first_latency", 64'(last_lat), 64'(ST));

        // Table vectors, back to back.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tv[i].a, tv[i].b, tv[i].s);
            next_exp = {tv[i].r, tv[i].c, tv[i].v, tv[i].z};
            cycle();
        end
        drain("drain_table");

        // Stream of 8 with a 3-cycle stall after the third.
        n_out = 0;
        lat_q.delete();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'(i), 32'(16 * i), 1'b0);
            cycle();
        end
        bus.stall = 1'b1;
        drive(1'b1, 32'd4, 32'd64, 1'b0);
        snap = outs();
        repeat (3) begin
            cycle();
            check("stall_frozen", 64'(outs()), 64'(snap));
        end
        bus.stall = 1'b0;
        for (int i = 4; i <= 8; i++) begin
            drive(1'b1, 32'(i), 32'(16 * i), 1'b0);
            cycle();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 12 && n_out < 8; i++) cycle();
        check("stream_count", 64'(n_out), 64'd8);
        if (lat_q.size() == 8) begin
            check("lat_op1", 64'(lat_q[0]), 64'(ST + 3));
            check("lat_op3", 64'(lat_q[2]), 64'(ST + 3));
            check("lat_op8", 64'(lat_q[7]), 64'(ST));
        end
        drain("drain_stall");

        // Flush with three in flight, together with stall and a new op.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0);
            cycle();
        end
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive(1'b1, 32'h0BAD0BAD, 32'h1, 1'b0);
        cycle();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (4) begin
            cycle();
            check("flush_valid", 64'(bus.out_valid), 64'd0);
        end

        // Valid output held by stall, then async reset between edges.
        n_out = 0;
        drive(1'b1, 32'h00001234, 32'h00000001, 1'b0);
        cycle();
        drive(1'b1, 32'h00000055, 32'h000000AA, 1'b1);
        cycle();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8 && n_out == 0; i++) cycle();
        check("x_valid", 64'(bus.out_valid), 64'd1);
        bus.stall = 1'b1;
        snap = outs();
        repeat (2) begin
            cycle();
            check("stall_hold", 64'(outs()), 64'(snap));
        end
        #3 reset = 1'b1;
        #1 check("async_reset", 64'(outs()), 64'd0);
        q_exp.delete();
        q_cyc.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.stall = 1'b0;
        seen      = 1'b0;
        repeat (6) begin
            cycle();
            seen |= bus.out_valid;
        end
        check("after_reset_valid", 64'(seen), 64'd0);

        // Random stream with bubbles and occasional stalls.
        for (int i = 0; i < 60; i++) begin
            bus.stall = ($urandom_range(0, 5) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1);
            cycle();
        end
        bus.stall = 1'b0;
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
